tick_rate_sel: RTL

//   Upstream rate source for the LED blinker. Debounces one board pushbutton; each

---
 rtl/tick_rate_sel.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tick_rate_sel.sv
// tick_rate_sel: debounced pushbutton steps through four blink rates and emits a one-cycle tick at the selected rate.
// Optional feature: define TICK_SEL_PAUSE_EN to add a debounced pause key (pause_n in, paused out).

module tick_rate_sel_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned DCNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

  state_e            state_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              ks;

  assign ks      = sync2_q;
  assign press_o = (state_q == PRESS_CHK) && !ks && (dcnt_q == DCNT_LAST);

  // The FSM only ever looks at the synchronized key; the shared counter times both press and release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE: begin
          if (!ks) begin
            state_q <= PRESS_CHK;
            dcnt_q  <= '0;
          end
        end
        PRESS_CHK: begin
          if (ks) begin
            state_q <= IDLE;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q <= HELD;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        HELD: begin
          if (ks) begin
            state_q <= REL_CHK;
            dcnt_q  <= '0;
          end
        end
        REL_CHK: begin
          if (!ks) begin
            state_q <= HELD;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

module tick_rate_sel #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned RATE0_DIV    = 50_000_000,
  parameter int unsigned RATE1_DIV    = 25_000_000,
  parameter int unsigned RATE2_DIV    = 12_500_000,
  parameter int unsigned RATE3_DIV    = 6_250_000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       key_n,
`ifdef TICK_SEL_PAUSE_EN
  input  logic       pause_n,
  output logic       paused,
`endif
  output logic       tick,
  output logic [1:0] rate_idx
);

  localparam int unsigned MAX01   = (RATE0_DIV > RATE1_DIV) ? RATE0_DIV : RATE1_DIV;
  localparam int unsigned MAX23   = (RATE2_DIV > RATE3_DIV) ? RATE2_DIV : RATE3_DIV;
  localparam int unsigned MAX_DIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned PCNT_W  = $clog2(MAX_DIV);

  typedef logic [PCNT_W-1:0] pcnt_t;

  logic [1:0] rate_q;
  logic [1:0] rate_d;
  pcnt_t      pcnt_q;
  pcnt_t      pcnt_d;
  pcnt_t      pcntLast;
  logic       tick_q;
  logic       tick_d;
  logic       ratePress;
  logic       hold;

  tick_rate_sel_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) rateDb (
    .clk_i  (clk_50),
    .rst_i  (rst),
    .key_n_i(key_n),
    .press_o(ratePress)
  );

`ifdef TICK_SEL_PAUSE_EN
  logic pausePress;
  logic paused_q;
  logic paused_d;

  tick_rate_sel_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) pauseDb (
    .clk_i  (clk_50),
    .rst_i  (rst),
    .key_n_i(pause_n),
    .press_o(pausePress)
  );

  // The prescaler also holds on the unpause edge so counting restarts one cycle later from the held value.
  assign paused_d = paused_q ^ pausePress;
  assign hold     = paused_q | paused_d;
  assign paused   = paused_q;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    case (rate_q)
      2'd0:    pcntLast = pcnt_t'(RATE0_DIV - 1);
      2'd1:    pcntLast = pcnt_t'(RATE1_DIV - 1);
      2'd2:    pcntLast = pcnt_t'(RATE2_DIV - 1);
      default: pcntLast = pcnt_t'(RATE3_DIV - 1);
    endcase
  end

  // A rate change restarts the period and swallows any tick due on that edge.
  always_comb begin
    rate_d = rate_q;
    pcnt_d = pcnt_q;
    tick_d = 1'b0;
    if (ratePress) begin
      rate_d = rate_q + 2'd1;
      pcnt_d = '0;
    end else if (!hold) begin
      if (pcnt_q == pcntLast) begin
        pcnt_d = '0;
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + pcnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      rate_q <= 2'd0;
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      rate_q <= rate_d;
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick     = tick_q;
  assign rate_idx = rate_q;

endmodule
